serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 148 ++++++++++++++
 tb/tb_serial_subtractor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b - bin mod 2^WIDTH.
// One bit per clock, LSB first; the result and borrow-out are registered and
// stay stable between completions.
//
// Ports
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request, sampled only while idle
//   a, b   in   minuend / subtrahend (WIDTH), captured on the accepting edge
//   bin    in   borrow-in, captured on the accepting edge
//   busy   out  high in RUN and DONE
//   done   out  one-cycle completion pulse
//   diff   out  registered result (WIDTH)
//   bout   out  registered borrow-out (1 when a < b + bin, unsigned)
//   ovf    out  registered two's-complement overflow, only when
//               SERIAL_SUBTRACTOR_OVF_EN is defined
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // operand shift registers, LSB consumed each RUN edge
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;  // partial result, filled from the MSB end
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             bit_d, brw_nx;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;  // captured sign bits
  logic             ovf_q, ovf_d;
`endif

  // full-subtractor cell on the current LSBs
  assign bit_d  = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nx;
        acc_d = {bit_d, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // last bit: publish the whole word at once so diff never shows partials
          diff_d  = {bit_d, acc_q[WIDTH-1:1]};
          bout_d  = brw_nx;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d   = (amsb_q != bmsb_q) && (bit_d != amsb_q);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=4): directed cases then random
// operations with held start, operand changes during RUN and reset injection.
// The driver pushes the arithmetic expectation on every accepted start; an
// independent monitor pops and compares on each done pulse.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
  logic         ovf_w;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_w),
`endif
    .bout(bout)
  );
`ifndef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           c;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_err = 0, cyc = 0;
  logic rst_seen = 1'b0;
  logic [W-1:0] held_d = '0;
  logic held_b = 1'b0, held_o = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] av, bv, input logic bi, input int c);
    exp_t e;
    int   r;
    r    = int'(av) - int'(bv) - int'(bi);
    e.d  = W'(r);
    e.bo = (r < 0);
    e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
    e.c  = c;
    return e;
  endfunction

  // one cycle of stimulus, applied on the falling edge
  task automatic drive(input logic st, input logic [W-1:0] av, bv, input logic bi,
                       input logic rn, output logic acc);
    @(negedge clk);
    start = st; a = av; b = bv; bin = bi; rst_n = rn;
    acc = st && !busy && rn;
    if (acc) q.push_back(model(av, bv, bi, cyc));
  endtask

  // rst_at: post-accept cycle (1..W+1) whose following edge sees rst_n=0, 0 = none
  task automatic run_op(input logic [W-1:0] av, bv, input logic bi,
                        input logic hold, input logic chg, input int rst_at);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 3 * W && !acc; t++) drive(1'b1, av, bv, bi, 1'b1, acc);
    chk("accept", 32'(acc), 32'd1);
    for (int k = 1; k <= W + 1; k++)
      drive(hold, chg ? W'($urandom) : av, chg ? W'($urandom) : bv,
            chg ? 1'($urandom) : bi, k != rst_at, acc);
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_seen = !rst_n;
    if (!rst_n) q.delete();
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_seen) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_ovf", 32'(ovf_w), 32'd0);
`endif
        held_d = '0; held_b = 1'b0; held_o = 1'b0;
      end else if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = q.pop_front();
          chk("diff", 32'(diff), 32'(e.d));
          chk("bout", 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          chk("ovf", 32'(ovf_w), 32'(e.ov));
`endif
          chk("latency", 32'(cyc - e.c), 32'(W + 1));
          chk("busy_in_done", 32'(busy), 32'd1);
          held_d = e.d; held_b = e.bo; held_o = e.ov;
        end
      end else begin
        chk("diff_hold", 32'(diff), 32'(held_d));
        chk("bout_hold", 32'(bout), 32'(held_b));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf_hold", 32'(ovf_w), 32'(held_o));
`endif
        if (q.size() != 0 && cyc - q[0].c > W + 1) begin
          chk("done_timeout", 32'(cyc - q[0].c), 32'(W + 1));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic acc;
    int   r;
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
    drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
    // directed
    run_op(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 0);
    run_op(4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 0);
    run_op(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 0);
    run_op(4'b1010, 4'b0101, 1'b1, 1'b0, 1'b1, 0);
    run_op(4'b0111, 4'b0011, 1'b0, 1'b1, 1'b0, 0);  // start held through RUN
    run_op(4'b0111, 4'b0011, 1'b0, 1'b0, 1'b0, 2);  // reset on second RUN edge
    run_op(4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0, 0);
    run_op(4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0, 0);
    run_op(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0, 0);
    run_op(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 0);
    run_op(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, W + 1);  // reset in DONE
    // random
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), r);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) drive(1'b0, W'($urandom), W'($urandom),
                                            1'($urandom), 1'b1, acc);
    end
    repeat (2 * W + 2) drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
